// File: rtl/mem_lsu_pkg.sv
// mem_lsu shared definitions: opcodes, instruction fields,
// FSM states and the memory-op decoder.
package mem_lsu_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    typedef struct packed {
        logic  is_mem;
        logic  is_load;
        logic  sext;
        size_e size;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d.is_mem  = 1'b1;
        d.is_load = 1'b1;
        d.sext    = 1'b0;
        d.size    = SZ_W;
        case (op)
            OP_LW:  d.size = SZ_W;
            OP_LH:  begin d.size = SZ_H; d.sext = 1'b1; end
            OP_LHU: d.size = SZ_H;
            OP_LB:  begin d.size = SZ_B; d.sext = 1'b1; end
            OP_LBU: d.size = SZ_B;
            OP_SW:  d.is_load = 1'b0;
            OP_SH:  begin d.is_load = 1'b0; d.size = SZ_H; end
            OP_SB:  begin d.is_load = 1'b0; d.size = SZ_B; end
            default: begin
                d.is_mem  = 1'b0;
                d.is_load = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Byte-lane steering: store enables/data, load extract/extend
// and alignment check for the MEM-stage load/store unit.
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  size_e       size_i,
    input  logic        sext_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_val_o,
    output logic        misaligned_o
);

    logic [31:0] rsh;

    // Bring the addressed lane down to bit 0 before extending.
    assign rsh = rdata_i >> {off_i, 3'b000};

    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = st_data_i;
        ld_val_o     = rsh;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_B: begin
                be_o     = 4'b0001 << off_i;
                wdata_o  = {4{st_data_i[7:0]}};
                ld_val_o = {{24{sext_i & rsh[7]}}, rsh[7:0]};
            end
            SZ_H: begin
                be_o         = 4'b0011 << off_i;
                wdata_o      = {2{st_data_i[15:0]}};
                ld_val_o     = {{16{sext_i & rsh[15]}}, rsh[15:0]};
                misaligned_o = off_i[0];
            end
            default: misaligned_o = |off_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store initiator: drives a req/ack data bus,
// stalls the pipeline meanwhile and merges load results into WB.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_mem,
    input  logic [31:0]       rt_data_mem,
    input  logic [31:0]       alu_out_mem,
    input  logic [31:0]       pc_mem,
    input  logic [31:0]       reg_data_in,
    input  logic [4:0]        reg_addr_in,
    input  logic              reg_write_in,
    output logic [31:0]       reg_data_out,
    output logic [4:0]        reg_addr_out,
    output logic              reg_write_out,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    output logic              addr_err,
    output logic              bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       ld_q, ld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              abort_q, abort_d;
    logic              aerr_q, aerr_d;
    logic              berr_q, berr_d;

    dec_t        dec;
    logic [4:0]  rt;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] ld_val;
    logic        misaligned;
    logic        unused_ok;

    assign dec       = decode(instr_mem[OP_HI:OP_LO]);
    assign rt        = instr_mem[RT_HI:RT_LO];
    assign unused_ok = ^{pc_mem, instr_mem[25:21], instr_mem[15:0]};

    mem_lsu_lane u_lane (
        .size_i       (dec.size),
        .sext_i       (dec.sext),
        .off_i        (alu_out_mem[1:0]),
        .st_data_i    (rt_data_mem),
        .rdata_i      (bus_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .ld_val_o     (ld_val),
        .misaligned_o (misaligned)
    );

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        ld_d          = ld_q;
        cnt_d         = cnt_q;
        abort_d       = abort_q;
        aerr_d        = 1'b0;
        berr_d        = 1'b0;
        stall         = 1'b0;
        reg_write_out = reg_write_in;
        reg_addr_out  = reg_addr_in;
        reg_data_out  = reg_data_in;
        unique case (state_q)
            ST_IDLE: begin
                if (dec.is_mem) begin
                    reg_write_out = 1'b0;
                    if (misaligned) begin
                        aerr_d = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        we_d    = ~dec.is_load;
                        addr_d  = {alu_out_mem[ADDR_W-1:2], 2'b00};
                        be_d    = lane_be;
                        wdata_d = lane_wdata;
                        cnt_d   = '0;
                        abort_d = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                stall         = 1'b1;
                reg_write_out = 1'b0;
                // Ack wins over the timeout in the last waiting cycle.
                if (bus_ack) begin
                    if (dec.is_load) ld_d = ld_val;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                reg_write_out = dec.is_load & ~abort_q & (rt != 5'd0);
                reg_addr_out  = rt;
                reg_data_out  = ld_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end

    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign addr_err  = aerr_q;
    assign bus_err   = berr_q;

endmodule
